// File: rtl/spi_regmap_pkg.sv
// Shared types and the CRC-8 helper for the SPI register-map slave.
package spi_regmap_pkg;

  typedef enum logic [7:0] {
    CMD_RD_SAMPLES = 8'h01,
    CMD_WR_COEFF   = 8'h02,
    CMD_RD_COEFF   = 8'h03
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    RD_DATA = 3'd3,
    WR_DATA = 3'd4,
    IGNORE  = 3'd5
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One bit of a non-reflected CRC-8, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Oversamples the SPI pins into clk_48: 2-FF synchronisers plus a third stage for edges.
// All strobes and levels leave on the same registered stage so they stay aligned.
module spi_pin_sync (
  input  logic clk_48,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_act,
  output logic cs_rise,
  output logic mosi_s
);

  logic [2:0] sclk_r;
  logic [2:0] cs_r;
  logic [1:0] mosi_r;
  logic       sclk_rise_r;
  logic       sclk_fall_r;
  logic       cs_act_r;
  logic       cs_rise_r;
  logic       mosi_s_r;

  // Synchroniser chains and edge strobes.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      sclk_r      <= 3'b000;
      cs_r        <= 3'b111;
      mosi_r      <= 2'b00;
      sclk_rise_r <= 1'b0;
      sclk_fall_r <= 1'b0;
      cs_act_r    <= 1'b0;
      cs_rise_r   <= 1'b0;
      mosi_s_r    <= 1'b0;
    end else begin
      sclk_r      <= {sclk_r[1:0], sclk};
      cs_r        <= {cs_r[1:0], cs_n};
      mosi_r      <= {mosi_r[0], mosi};
      sclk_rise_r <= sclk_r[1] & ~sclk_r[2];
      sclk_fall_r <= ~sclk_r[1] & sclk_r[2];
      cs_rise_r   <= cs_r[1] & ~cs_r[2];
      cs_act_r    <= ~cs_r[1];
      mosi_s_r    <= mosi_r[1];
    end
  end

  assign sclk_rise = sclk_rise_r;
  assign sclk_fall = sclk_fall_r;
  assign cs_act    = cs_act_r;
  assign cs_rise   = cs_rise_r;
  assign mosi_s    = mosi_s_r;

endmodule

// File: rtl/spi_regmap_slave.sv
// SPI mode-0 slave: coherent sample snapshot reads plus coefficient register writes/reads.
// Define SPI_REGMAP_CRC_EN to append/check a CRC-8 byte on every payload.
module spi_regmap_slave
  import spi_regmap_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int SAMPLE_W = 16,
  parameter int N_COEFF  = 10,
  parameter int COEFF_W  = 64
) (
  input  logic                       clk_48,
  input  logic                       reset,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       mosi,
  output logic                       miso,
  input  logic [N_CH*SAMPLE_W-1:0]   sample_in,
  input  logic                       sample_valid,
  output logic [N_COEFF*COEFF_W-1:0] coeff_out,
  output logic                       coeff_update
);

  localparam int SMP_W = N_CH * SAMPLE_W;
  localparam int TX_W  = (SMP_W > COEFF_W) ? SMP_W : COEFF_W;
`ifdef SPI_REGMAP_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int MAX_BITS = TX_W + 16 + CRC_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] WR_END   = CNT_W'(16 + COEFF_W);
  localparam logic [CNT_W-1:0] WR_FULL  = CNT_W'(16 + COEFF_W + CRC_BITS);

  logic sclk_rise_s, sclk_fall_s, cs_act_s, cs_rise_s, mosi_s;

  spi_pin_sync u_sync (
    .clk_48    (clk_48),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s),
    .cs_act    (cs_act_s),
    .cs_rise   (cs_rise_s),
    .mosi_s    (mosi_s)
  );

  state_e                     state_r;
  logic [CNT_W-1:0]           bit_cnt_r;
  logic [6:0]                 rx_r;
  logic                       cmd_wr_r;
  logic [7:0]                 idx_r;
  logic [SMP_W-1:0]           hold_r;
  logic [TX_W-1:0]            tx_r;
  logic [COEFF_W-1:0]         shadow_r;
  logic                       miso_r;
  logic [N_COEFF*COEFF_W-1:0] coeff_out_r;
  logic                       coeff_update_r;
`ifdef SPI_REGMAP_CRC_EN
  logic [7:0]                 crc_r;
  logic [CNT_W-1:0]           tx_left_r;
`endif

  logic [7:0]         rx_byte_s;
  logic [COEFF_W-1:0] rd_word_s;
  logic               idx_ok_s;
  logic               crc_ok_s;

  assign rx_byte_s = {rx_r, mosi_s};
  assign idx_ok_s  = int'(idx_r) < N_COEFF;
`ifdef SPI_REGMAP_CRC_EN
  // Running CRC over index+payload+trailer is zero when the trailer matches.
  assign crc_ok_s  = (crc_r == 8'h00);
`else
  assign crc_ok_s  = 1'b1;
`endif

  // Coefficient selected by the index byte being received; out-of-range reads as zero.
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < N_COEFF; i++) begin
      rd_word_s = (int'(rx_byte_s) == i) ? coeff_out_r[(N_COEFF-1-i)*COEFF_W +: COEFF_W] : rd_word_s;
    end
  end

  // Frame FSM, shift registers, coefficient commit and MISO driver.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      bit_cnt_r      <= '0;
      rx_r           <= 7'd0;
      cmd_wr_r       <= 1'b0;
      idx_r          <= 8'd0;
      hold_r         <= '0;
      tx_r           <= '0;
      shadow_r       <= '0;
      miso_r         <= 1'b0;
      coeff_out_r    <= '0;
      coeff_update_r <= 1'b0;
`ifdef SPI_REGMAP_CRC_EN
      crc_r          <= 8'h00;
      tx_left_r      <= '0;
`endif
    end else begin
      coeff_update_r <= 1'b0;
      if (sample_valid) hold_r <= sample_in;

      if (cs_rise_s && state_r == WR_DATA && bit_cnt_r >= WR_FULL && idx_ok_s && crc_ok_s) begin
        for (int i = 0; i < N_COEFF; i++) begin
          if (int'(idx_r) == i) coeff_out_r[(N_COEFF-1-i)*COEFF_W +: COEFF_W] <= shadow_r;
        end
        coeff_update_r <= 1'b1;
      end

      if (!cs_act_s) begin
        state_r   <= IDLE;
        bit_cnt_r <= '0;
        rx_r      <= 7'd0;
        tx_r      <= '0;
        shadow_r  <= '0;
        miso_r    <= 1'b0;
`ifdef SPI_REGMAP_CRC_EN
        crc_r     <= 8'h00;
        tx_left_r <= '0;
`endif
      end else begin
        if (state_r == IDLE) state_r <= CMD;

        if (sclk_rise_s) begin
          rx_r <= rx_byte_s[6:0];
          if (bit_cnt_r != CNT_MAX) bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          case (state_r)
            CMD: begin
              if (bit_cnt_r == CMD_LAST) begin
`ifdef SPI_REGMAP_CRC_EN
                crc_r <= 8'h00;
`endif
                case (rx_byte_s)
                  CMD_RD_SAMPLES: begin
                    state_r <= RD_DATA;
                    tx_r    <= TX_W'(hold_r) << (TX_W - SMP_W);
`ifdef SPI_REGMAP_CRC_EN
                    tx_left_r <= CNT_W'(SMP_W);
`endif
                  end
                  CMD_WR_COEFF: begin
                    state_r  <= ADDR;
                    cmd_wr_r <= 1'b1;
                  end
                  CMD_RD_COEFF: begin
                    state_r  <= ADDR;
                    cmd_wr_r <= 1'b0;
                  end
                  default: state_r <= IGNORE;
                endcase
              end
            end
            ADDR: begin
`ifdef SPI_REGMAP_CRC_EN
              crc_r <= crc8_step(crc_r, mosi_s);
`endif
              if (bit_cnt_r == IDX_LAST) begin
                idx_r <= rx_byte_s;
                if (cmd_wr_r) begin
                  state_r <= WR_DATA;
                end else begin
                  state_r <= RD_DATA;
                  tx_r    <= TX_W'(rd_word_s) << (TX_W - COEFF_W);
`ifdef SPI_REGMAP_CRC_EN
                  crc_r     <= 8'h00;
                  tx_left_r <= CNT_W'(COEFF_W);
`endif
                end
              end
            end
            WR_DATA: begin
              if (bit_cnt_r < WR_END) shadow_r <= {shadow_r[COEFF_W-2:0], mosi_s};
`ifdef SPI_REGMAP_CRC_EN
              if (bit_cnt_r < WR_FULL) crc_r <= crc8_step(crc_r, mosi_s);
`endif
            end
            default: ;
          endcase
        end

        // Zeros shift in behind the payload, so bits past the end read 0.
        if (sclk_fall_s && state_r == RD_DATA) begin
`ifdef SPI_REGMAP_CRC_EN
          if (tx_left_r != '0) begin
            miso_r    <= tx_r[TX_W-1];
            tx_r      <= tx_r << 1;
            crc_r     <= crc8_step(crc_r, tx_r[TX_W-1]);
            tx_left_r <= tx_left_r - CNT_W'(1);
          end else begin
            miso_r <= crc_r[7];
            crc_r  <= {crc_r[6:0], 1'b0};
          end
`else
          miso_r <= tx_r[TX_W-1];
          tx_r   <= tx_r << 1;
`endif
        end
      end
    end
  end

  assign miso         = miso_r;
  assign coeff_out    = coeff_out_r;
  assign coeff_update = coeff_update_r;

endmodule
